am_cmd_sequencer: RTL and testbench

Sequential front/back end for the combinational `AM` arithmetic unit. It accepts operand commands over a valid/ready handshake and drives `A`/`B`/`Sel` into `AM` from registers. After a programmable settle time it captures `Out`/`Ovf` and queues each result, tagged with its select code, in a small result FIFO for the downstream consumer. A sweep mode runs all 16 `AM` functions on one operand pair without further commands.

---
 rtl/am_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_am_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/am_cmd_sequencer.sv
// am_cmd_sequencer: registered operand driver, settle timer and result FIFO for AM.
// Optional saturating overflow counter enabled by `define AM_SEQ_OVF_CNT_EN.
module am_cmd_sequencer #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [3:0]  in_sel,
    input  logic        in_sweep,
    output logic [3:0]  am_a,
    output logic [3:0]  am_b,
    output logic [3:0]  am_sel,
    input  logic [15:0] am_out,
    input  logic        am_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic [3:0]  out_sel,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 21;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [3:0]      sel_q, sel_d;
    logic            sweep_q, sweep_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            push;
    logic            pop;
    logic            full;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [EW-1:0]   head;

    // Full when the count MSB is set, since DEPTH is a power of two.
    assign full = count_q[AW];
    assign pop  = (count_q != '0) && out_ready;

    // Sequencer next-state: accept, settle countdown, capture with backpressure.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        sweep_d = sweep_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sweep_d = in_sweep;
                    sel_d   = in_sweep ? 4'd0 : in_sel;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                if (!full) begin
                    push = 1'b1;
                    if (sweep_q && (sel_q != 4'hF)) begin
                        sel_d   = sel_q + 4'd1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        sweep_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; operands only change when leaving IDLE or CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            sweep_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO next-state: write at tail, advance head on pop, track occupancy.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = {sel_q, am_ovf, am_out};
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers; entries are zeroed so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef AM_SEQ_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of pushed results that overflowed.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (push && am_ovf && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    // Overflow counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'd0;
`endif

    assign head      = mem_q[rptr_q];
    assign out_sel   = head[20:17];
    assign out_ovf   = head[16];
    assign out_data  = head[15:0];
    assign out_valid = (count_q != '0);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign am_a      = a_q;
    assign am_b      = b_q;
    assign am_sel    = sel_q;

endmodule

// File: tb/tb_am_cmd_sequencer.sv
// tb_am_cmd_sequencer: directed bench for am_cmd_sequencer with a behavioural AM.
// Expectations follow `define AM_SEQ_OVF_CNT_EN when it is set.
module tb_am_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [3:0]  in_sel;
    logic        in_sweep;
    logic [3:0]  am_a;
    logic [3:0]  am_b;
    logic [3:0]  am_sel;
    logic [15:0] am_out;
    logic        am_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic [3:0]  out_sel;
    logic        busy;
    logic [7:0]  ovf_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef AM_SEQ_OVF_CNT_EN
    localparam logic [7:0] OVF1 = 8'd1;
`else
    localparam logic [7:0] OVF1 = 8'd0;
`endif

    am_cmd_sequencer #(.DEPTH(4), .SETTLE_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .in_sweep  (in_sweep),
        .am_a      (am_a),
        .am_b      (am_b),
        .am_sel    (am_sel),
        .am_out    (am_out),
        .am_ovf    (am_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_sel   (out_sel),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural AM: sel 3 unsigned mul, sel 12 4-bit add, sel 15 signed mul.
    function automatic logic [16:0] am_model(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] s);
        logic [3:0]  sum;
        logic [15:0] p;
        logic        v;
        case (s)
            4'd3: begin
                p = {8'd0, 4'd0, a} * {8'd0, 4'd0, b};
                return {1'b0, p};
            end
            4'd12: begin
                sum = a + b;
                v   = (a[3] == b[3]) && (sum[3] != a[3]);
                return {v, 12'd0, sum};
            end
            4'd15: begin
                p = {{12{a[3]}}, a} * {{12{b[3]}}, b};
                return {1'b0, p};
            end
            default: return {s[0] ^ a[0], s, ~a, b, a ^ b};
        endcase
    endfunction

    always_comb {am_ovf, am_out} = am_model(am_a, am_b, am_sel);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns just after the accepting edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s, input logic sw);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
        in_sweep = sw;
        step();
        in_valid = 1'b0;
    endtask

    // Collect n sweep results in order; out_ready must already be high.
    task automatic collect(input int n, input logic [3:0] a,
                           input logic [3:0] b, input logic last_busy);
        int got = 0;
        int cyc = 0;
        logic [16:0] e;
        while (got < n && cyc < 200) begin
            if (out_valid) begin
                e = am_model(a, b, got[3:0]);
                chk($sformatf("sel%0d", got), out_sel, got);
                chk($sformatf("data%0d", got), out_data, e[15:0]);
                chk($sformatf("ovf%0d", got), out_ovf, e[16]);
                got++;
                if (got == n) chk("busy_last", busy, last_busy);
            end
            if (got < n) begin
                step();
                cyc++;
            end
        end
        chk("collect_count", got, n);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sel    = '0;
        in_sweep  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_am", {am_a, am_b, am_sel}, 0);
        chk("rst_head", {out_sel, out_ovf, out_data}, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        issue(4'b0111, 4'b0001, 4'd12, 1'b0);
        chk("add_busy", busy, 1);
        chk("add_in_ready", in_ready, 0);
        chk("add_am", {am_a, am_b, am_sel}, 12'h71C);
        step();
        chk("add_not_yet", out_valid, 0);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 16'h0008);
        chk("add_ovf", out_ovf, 1);
        chk("add_sel", out_sel, 12);
        chk("add_idle", busy, 0);
        chk("add_ovf_cnt", ovf_cnt, OVF1);
        step();
        chk("add_popped", out_valid, 0);

        issue(4'b1110, 4'b0011, 4'd15, 1'b0);
        step();
        step();
        chk("mul_valid", out_valid, 1);
        chk("mul_data", out_data, 16'hFFFA);
        chk("mul_ovf", out_ovf, 0);
        chk("mul_sel", out_sel, 15);
        step();

        issue(4'd3, 4'd5, 4'd9, 1'b1);
        collect(16, 4'd3, 4'd5, 1'b0);
        step();
        chk("sweep_drained", out_valid, 0);

        out_ready = 1'b0;
        issue(4'd3, 4'd5, 4'd0, 1'b1);
        repeat (20) step();
        chk("bp_valid", out_valid, 1);
        chk("bp_busy", busy, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_am_sel", am_sel, 4);
        chk("bp_head_sel", out_sel, 0);
        out_ready = 1'b1;
        collect(16, 4'd3, 4'd5, 1'b0);
        step();
        chk("bp_drained", out_valid, 0);

        issue(4'd3, 4'd5, 4'd0, 1'b1);
        collect(5, 4'd3, 4'd5, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_am", {am_a, am_b, am_sel}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_ovf_cnt", ovf_cnt, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        issue(4'b0111, 4'b0001, 4'd12, 1'b0);
        step();
        step();
        chk("post_valid", out_valid, 1);
        chk("post_head", {out_sel, out_ovf, out_data}, {4'd12, 1'b1, 16'h0008});
        chk("post_ovf_cnt", ovf_cnt, OVF1);
        issue(4'b1110, 4'b0011, 4'd15, 1'b0);
        step();
        step();
        out_ready = 1'b1;
        chk("post_head_kept", out_sel, 12);
        step();
        chk("post_second", {out_sel, out_ovf, out_data}, {4'd15, 1'b0, 16'hFFFA});
        step();
        chk("post_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
